// File: rtl/square_root_if.sv
// Start/busy/done handshake bundle for the two-lane square-root unit.
// The requester drives the master side; the unit sits on the slave side.
interface square_root_if #(
  parameter int word_size = 24
);
  logic                 start;
  logic [word_size-1:0] data_1;
  logic [word_size-1:0] data_2;
  logic [word_size-1:0] root_1;
  logic [word_size-1:0] root_2;
  logic                 busy;
  logic                 done;
  logic                 invalid_1;
  logic                 invalid_2;

  modport master (
    output start, data_1, data_2,
    input  root_1, root_2, busy, done, invalid_1, invalid_2
  );

  modport slave (
    input  start, data_1, data_2,
    output root_1, root_2, busy, done, invalid_1, invalid_2
  );
endinterface

// File: rtl/square_root.sv
// Two-lane iterative restoring square root; one root bit per clock per lane.
// Define SQRT_ROUND_EN to round the root to nearest instead of truncating.
module square_root #(
  parameter int word_size = 24,
  parameter int exp_width = 8
) (
  input  logic          clk,
  input  logic          rst,
  square_root_if.slave  bus
);
  localparam int M  = word_size - 1 - exp_width;
  localparam int R  = M + 1;
  localparam int N  = R / 2;
  localparam int CW = $clog2(N);
`ifdef SQRT_ROUND_EN
  localparam int RW = N + 1;
`else
  localparam int RW = N;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [R-1:0]         r_rad  [2];
  logic [N+1:0]         r_rem  [2];
  logic [N-1:0]         r_root [2];
  logic                 r_neg  [2];
  logic [exp_width-1:0] r_eout [2];
  logic [word_size-1:0] r_res  [2];
  logic                 r_inv  [2];
  logic                 r_busy;
  logic                 r_done;

  logic [word_size-1:0] w_op        [2];
  logic [R-1:0]         w_load_rad  [2];
  logic [N+3:0]         w_shift     [2];
  logic [N+3:0]         w_trial     [2];
  logic                 w_keep      [2];
  logic [N+1:0]         w_next_rem  [2];
  logic [N-1:0]         w_next_root [2];
  logic [RW-1:0]        w_final     [2];
  logic [word_size-1:0] w_word      [2];

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    w_op[0] = bus.data_1;
    w_op[1] = bus.data_2;
    for (int l = 0; l < 2; l++) begin
      // An odd exponent is folded into the radicand so the exponent halves exactly.
      w_load_rad[l]  = {1'b0, w_op[l][word_size-2:exp_width]} << w_op[l][0];
      w_shift[l]     = {r_rem[l], r_rad[l][R-1 -: 2]};
      w_trial[l]     = w_shift[l] - {2'b00, r_root[l], 2'b01};
      w_keep[l]      = ~w_trial[l][N+3];
      w_next_rem[l]  = w_keep[l] ? w_trial[l][N+1:0] : w_shift[l][N+1:0];
      w_next_root[l] = {r_root[l][N-2:0], w_keep[l]};
`ifdef SQRT_ROUND_EN
      w_final[l]     = {1'b0, r_root[l]} + RW'(r_rem[l] > (N+2)'(r_root[l]));
`else
      w_final[l]     = r_root[l];
`endif
      w_word[l]      = {1'b0, M'(w_final[l]), r_eout[l]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        r_rad[l]  <= '0;
        r_rem[l]  <= '0;
        r_root[l] <= '0;
        r_neg[l]  <= 1'b0;
        r_eout[l] <= '0;
        r_res[l]  <= '0;
        r_inv[l]  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            for (int l = 0; l < 2; l++) begin
              r_rad[l]  <= w_load_rad[l];
              r_rem[l]  <= '0;
              r_root[l] <= '0;
              r_neg[l]  <= w_op[l][word_size-1];
              r_eout[l] <= w_op[l][exp_width-1:0] >> 1;
            end
            r_count <= CW'(N - 1);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          for (int l = 0; l < 2; l++) begin
            r_rad[l]  <= r_rad[l] << 2;
            r_rem[l]  <= w_next_rem[l];
            r_root[l] <= w_next_root[l];
          end
          if (r_count == '0) begin
            r_state <= DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        DONE: begin
          for (int l = 0; l < 2; l++) begin
            r_res[l] <= r_neg[l] ? '0 : w_word[l];
            r_inv[l] <= r_neg[l];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.root_1    = r_res[0];
  assign bus.root_2    = r_res[1];
  assign bus.invalid_1 = r_inv[0];
  assign bus.invalid_2 = r_inv[1];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_square_root.sv
// Directed self-checking bench for square_root: reset, lane results, handshake, mid-op reset.
// Expected roots are hand-computed; SQRT_ROUND_EN selects the rounded max-radicand value.
module tb_square_root;
  localparam int WS = 24;
`ifdef SQRT_ROUND_EN
  localparam logic [WS-1:0] MAX_ROOT = 24'h010000;
`else
  localparam logic [WS-1:0] MAX_ROOT = 24'h00FF00;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  square_root_if #(.word_size(WS)) bus ();

  square_root #(.word_size(WS), .exp_width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one op and wait (bounded) for done; lat stays -1 if done never arrives.
  task automatic run_op(input logic [WS-1:0] d1, input logic [WS-1:0] d2,
                        output int lat, output logic [1:0] busy_seen);
    bus.data_1 = d1;
    bus.data_2 = d2;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.data_1 = 24'h801FFF;
    bus.data_2 = 24'h801FFF;
    lat        = -1;
    busy_seen  = 2'b00;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) busy_seen[0] = bus.busy;
      if (c == 8) busy_seen[1] = bus.busy;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.data_1 = '0;
    bus.data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.root_1, bus.root_2} !== 48'h0) begin
      failures++;
      $display("FAIL reset_roots: got %h %h expected 000000 000000", bus.root_1, bus.root_2);
    end
    checks++;
    if ({bus.busy, bus.done, bus.invalid_1, bus.invalid_2} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/inv1/inv2=%b expected 0000",
               {bus.busy, bus.done, bus.invalid_1, bus.invalid_2});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_even_odd();
    int lat;
    logic [1:0] bs;
    run_op(24'h001004, 24'h000803, lat, bs);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL even_odd_latency: got %0d expected 9", lat);
    end
    checks++;
    if (bs !== 2'b11) begin
      failures++;
      $display("FAIL even_odd_busy: got busy@1,@8=%b expected 11", {bs[0], bs[1]});
    end
    checks++;
    if ({bus.root_1, bus.invalid_1} !== {24'h000402, 1'b0}) begin
      failures++;
      $display("FAIL even_exp_lane1: got %h inv=%b expected 000402 inv=0", bus.root_1, bus.invalid_1);
    end
    checks++;
    if ({bus.root_2, bus.invalid_2} !== {24'h000401, 1'b0}) begin
      failures++;
      $display("FAIL odd_exp_lane2: got %h inv=%b expected 000401 inv=0", bus.root_2, bus.invalid_2);
    end
  endtask

  task automatic test_max_radicand();
    int lat;
    logic [1:0] bs;
    run_op(24'h7FFF01, 24'h000803, lat, bs);
    checks++;
    if ({bus.root_1, bus.invalid_1} !== {MAX_ROOT, 1'b0}) begin
      failures++;
      $display("FAIL max_radicand: got %h inv=%b expected %h inv=0", bus.root_1, bus.invalid_1, MAX_ROOT);
    end
    checks++;
    if (bus.root_2 !== 24'h000401) begin
      failures++;
      $display("FAIL max_other_lane: got %h expected 000401", bus.root_2);
    end
  endtask

  task automatic test_neg_zero();
    int lat;
    logic [1:0] bs;
    run_op(24'h801004, 24'h000006, lat, bs);
    checks++;
    if ({bus.root_1, bus.invalid_1} !== {24'h000000, 1'b1}) begin
      failures++;
      $display("FAIL negative_lane1: got %h inv=%b expected 000000 inv=1", bus.root_1, bus.invalid_1);
    end
    checks++;
    if ({bus.root_2, bus.invalid_2} !== {24'h000003, 1'b0}) begin
      failures++;
      $display("FAIL zero_lane2: got %h inv=%b expected 000003 inv=0", bus.root_2, bus.invalid_2);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got %b expected 0", bus.done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.root_1, bus.invalid_1, bus.root_2, bus.invalid_2} !==
        {24'h000000, 1'b1, 24'h000003, 1'b0}) begin
      failures++;
      $display("FAIL result_hold: got %h %b %h %b expected 000000 1 000003 0",
               bus.root_1, bus.invalid_1, bus.root_2, bus.invalid_2);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int first_at = -1;
    int second_at = -1;
    logic [2*WS-1:0] res1 = '0;
    logic [2*WS-1:0] res2 = '0;
    bus.data_1 = 24'h001004;
    bus.data_2 = 24'h000803;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.data_1 = 24'h000006;
    bus.data_2 = 24'h7FFF01;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 10) begin
        bus.data_1 = 24'h801004;
        bus.data_2 = 24'h801004;
      end
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          first_at = c;
          res1 = {bus.root_1, bus.root_2};
        end else if (n_done == 2) begin
          second_at = c;
          res2 = {bus.root_1, bus.root_2};
        end
      end
      if (c == 19) bus.start = 1'b0;
    end
    checks++;
    if (n_done !== 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 2", n_done);
    end
    checks++;
    if ({first_at, second_at} !== {32'd9, 32'd19}) begin
      failures++;
      $display("FAIL b2b_timing: got %0d,%0d expected 9,19", first_at, second_at);
    end
    checks++;
    if (res1 !== {24'h000402, 24'h000401}) begin
      failures++;
      $display("FAIL b2b_first_result: got %h expected 000402000401", res1);
    end
    checks++;
    if (res2 !== {24'h000003, MAX_ROOT}) begin
      failures++;
      $display("FAIL b2b_second_result: got %h expected 000003%h", res2, MAX_ROOT);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_calc();
    int n_done = 0;
    int lat;
    logic [1:0] bs;
    bus.data_1 = 24'h001004;
    bus.data_2 = 24'h000803;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_flags: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
    checks++;
    if ({bus.root_1, bus.root_2} !== 48'h0) begin
      failures++;
      $display("FAIL midreset_roots: got %h %h expected 000000 000000", bus.root_1, bus.root_2);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d done pulses expected 0", n_done);
    end
    run_op(24'h7FFF01, 24'h001004, lat, bs);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL after_reset_latency: got %0d expected 9", lat);
    end
    checks++;
    if ({bus.root_1, bus.root_2} !== {MAX_ROOT, 24'h000402}) begin
      failures++;
      $display("FAIL after_reset_result: got %h %h expected %h 000402", bus.root_1, bus.root_2, MAX_ROOT);
    end
  endtask

  initial begin
    test_reset();
    test_even_odd();
    test_max_radicand();
    test_neg_zero();
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
